// File: rtl/lr3_pkg.sv
// Shared constants for the lr3 seven-segment scanner: digit count, blank codes,
// active-low segment patterns and the scan state encoding.
package lr3_pkg;

  localparam int DIGITS = 8;

  localparam logic [6:0] CAT_BLANK = 7'h7F;
  localparam logic [7:0] AN_BLANK  = 8'hFF;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/lr3_hex7seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module lr3_hex7seg (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  import lr3_pkg::*;

  always_comb begin
    seg_o = CAT_BLANK;
    case (hex_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = CAT_BLANK;
    endcase
  end

endmodule

// File: rtl/lr3_seg_scan.sv
// Multiplexed 8-digit hex display scanner with a BLANK/SHOW slot per digit,
// double-buffered data that only swaps at frame wrap, and optional leading-zero blanking.
module lr3_seg_scan #(
  parameter int DIGITS      = lr3_pkg::DIGITS,
  parameter bit LZ_SUPPRESS = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       DISP_CE,
  input  logic                       LOAD,
  input  logic [4*DIGITS-1:0]        DAT_I,
  input  logic [DIGITS-1:0]          DIG_EN,
  output logic [6:0]                 CAT,
  output logic [DIGITS-1:0]          AN,
  output logic                       FRAME_O,
  output logic [$clog2(DIGITS):0]    dbg_state
);
  import lr3_pkg::*;

  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Handshake note: LOAD is a fire-and-forget strobe with no ready; a newer LOAD
  // before the frame wrap simply overwrites the pending buffer.

  scan_state_t              state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [DIGITS-1:0]        an_q, an_d;
  logic [6:0]               cat_q, cat_d;
  logic                     frame_q, frame_d;
  logic [4*DIGITS-1:0]      pend_dat_q, pend_dat_d;
  logic [DIGITS-1:0]        pend_en_q, pend_en_d;
  logic                     pend_vld_q, pend_vld_d;
  logic [4*DIGITS-1:0]      shad_dat_q, shad_dat_d;
  logic [DIGITS-1:0]        shad_en_q, shad_en_d;

  logic [3:0]               cur_nib;
  logic [6:0]               cur_seg;
  logic                     upper_zero;
  logic                     digit_on;
  logic                     wrap;

  assign cur_nib    = shad_dat_q[{idx_q, 2'b00} +: 4];
  // Leading zero: this nibble and every more-significant one are zero.
  assign upper_zero = (shad_dat_q >> {idx_q, 2'b00}) == '0;
  assign digit_on   = shad_en_q[idx_q] && !(LZ_SUPPRESS && (idx_q != '0) && upper_zero);
  assign wrap       = DISP_CE && (state_q == ST_SHOW) && (idx_q == IDX_LAST);

  lr3_hex7seg u_dec (
    .hex_i (cur_nib),
    .seg_o (cur_seg)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    an_d       = an_q;
    cat_d      = cat_q;
    frame_d    = 1'b0;
    pend_dat_d = pend_dat_q;
    pend_en_d  = pend_en_q;
    pend_vld_d = pend_vld_q;
    shad_dat_d = shad_dat_q;
    shad_en_d  = shad_en_q;

    if (DISP_CE) begin
      case (state_q)
        ST_BLANK: begin
          state_d = ST_SHOW;
          an_d    = digit_on ? ~(DIGITS'(1) << idx_q) : AN_BLANK;
          cat_d   = digit_on ? cur_seg : CAT_BLANK;
        end
        ST_SHOW: begin
          state_d = ST_BLANK;
          an_d    = AN_BLANK;
          cat_d   = CAT_BLANK;
          idx_d   = wrap ? '0 : idx_q + 1'b1;
          frame_d = wrap;
        end
        default: state_d = ST_BLANK;
      endcase
    end

    // A LOAD landing on the wrap cycle is newer than pending, so it goes straight to shadow.
    if (wrap) begin
      if (LOAD) begin
        shad_dat_d = DAT_I;
        shad_en_d  = DIG_EN;
      end else if (pend_vld_q) begin
        shad_dat_d = pend_dat_q;
        shad_en_d  = pend_en_q;
      end
      pend_vld_d = 1'b0;
    end else if (LOAD) begin
      pend_dat_d = DAT_I;
      pend_en_d  = DIG_EN;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= ST_BLANK;
      idx_q      <= '0;
      an_q       <= AN_BLANK;
      cat_q      <= CAT_BLANK;
      frame_q    <= 1'b0;
      pend_dat_q <= '0;
      pend_en_q  <= '0;
      pend_vld_q <= 1'b0;
      shad_dat_q <= '0;
      shad_en_q  <= '1;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      cat_q      <= cat_d;
      frame_q    <= frame_d;
      pend_dat_q <= pend_dat_d;
      pend_en_q  <= pend_en_d;
      pend_vld_q <= pend_vld_d;
      shad_dat_q <= shad_dat_d;
      shad_en_q  <= shad_en_d;
    end
  end

  assign CAT       = cat_q;
  assign AN        = an_q;
  assign FRAME_O   = frame_q;
  assign dbg_state = {state_q, idx_q};

endmodule

// File: doc/lr3_seg_scan.md
LR3_SEG_SCAN -- requirements
Module: lr3_seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 8, meaning number of multiplexed digits (fixed 8 in this revision).
REQ-002 SHALL have parameter LZ_SUPPRESS, default 0, meaning blank leading zero digits when 1.
REQ-003 SHALL have port CLK  input  1  system clock; all state on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port DISP_CE  input  1  one-cycle refresh tick from the display CE generator.
REQ-006 SHALL have port LOAD  input  1  one-cycle strobe; capture DAT_I and DIG_EN.
REQ-007 SHALL have port DAT_I  input  32  eight hex nibbles; nibble i (DAT_I[4i+3:4i]) drives digit i.
REQ-008 SHALL have port DIG_EN  input  8  per-digit enable; 0 blanks that digit.
REQ-009 SHALL have port CAT  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 SHALL have port AN  output  8  digit anodes, active-low, one-hot-low or all-high, registered.
REQ-011 SHALL have port FRAME_O  output  1  one-cycle pulse at each frame start.

Function
REQ-012 SHALL hold a pending register (data+enable) and a shadow register; only shadow drives the display.
REQ-013 LOAD=1 SHALL write DAT_I/DIG_EN into pending and set pending-valid.
REQ-014 SHALL implement FSM states BLANK and SHOW with digit index idx (0..7); transitions only on DISP_CE=1.
REQ-015 BLANK+DISP_CE SHALL go to SHOW; next cycle AN has bit idx low (if digit shown) and CAT = decode(shadow nibble idx).
REQ-016 SHOW+DISP_CE SHALL go to BLANK; next cycle AN=8'hFF, CAT=7'h7F; idx increments modulo 8.
REQ-017 Frame SHALL be 16 DISP_CE ticks (8 digits x BLANK/SHOW); digit order 0,1,...,7.
REQ-018 On SHOW->BLANK with idx=7 (wrap to 0) SHALL pulse FRAME_O one cycle and copy pending to shadow if pending-valid, clearing pending-valid.
REQ-019 LOAD in the same cycle as a swap SHALL send DAT_I/DIG_EN directly to shadow, leaving pending-valid clear.
REQ-020 Displays SHALL never show partially updated data: shadow changes only at frame wrap.
REQ-021 Digit with shadow enable bit 0 SHALL keep AN=8'hFF and CAT=7'h7F during its SHOW slot; timing unchanged.
REQ-022 With LZ_SUPPRESS=1, digit i>0 SHALL be blanked when shadow nibbles i..7 are all zero; digit 0 never suppressed.
REQ-023 Decode SHALL be full hex: 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.
REQ-024 DISP_CE held high continuously SHALL advance one state per clock.
REQ-025 AN SHALL never have more than one bit low.

Reset
REQ-026 RST=0 SHALL asynchronously force state BLANK, idx=0, AN=8'hFF, CAT=7'h7F, FRAME_O=0, shadow data=0, shadow enables=8'hFF, pending cleared.
REQ-027 Reset mid-frame SHALL discard pending data; first DISP_CE after release enters SHOW for digit 0.

Structure
REQ-028 Segment constants, blank codes (CAT 7'h7F, AN 8'hFF) and DIGITS SHALL live in shared package lr3_pkg.
REQ-029 Hex-to-segment decode SHALL be sub-module lr3_hex7seg (4-bit in, 7-bit active-low out, combinational).

Verification
REQ-030 Reset, LOAD DAT_I=32'h76543210 DIG_EN=8'hFF, run 32 DISP_CE -> second frame AN low sequence FE,FD,...,7F with CAT 40,79,24,30,19,12,02,78; FRAME_O pulses every 16 ticks.
REQ-031 LOAD 32'hFFFFFFFF mid-frame (during digit 3) -> remaining digits of that frame show old data; FE.. digits show 7'h0E only after next FRAME_O.
REQ-032 LOAD coincident with wrap cycle, DAT_I=32'h000000AB -> very next frame shows digit0=7'h03, digit1=7'h08.
REQ-033 LZ_SUPPRESS=1, DAT_I=32'h00000050 -> digits 2..7 slots AN=8'hFF; digit1=7'h12, digit0=7'h40; DAT_I=0 -> only digit0 shows 7'h40.
REQ-034 DIG_EN=8'b10101010 -> even-digit SHOW slots keep AN=8'hFF; odd digits light; frame length still 16 ticks.
REQ-035 Assert RST at digit 5 SHOW -> AN=8'hFF, CAT=7'h7F same cycle without clock; after release first SHOW is digit 0 with CAT=7'h40.
